rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

RC4 keystream-generation and decryption stage for the key-search datapath. It runs after the KSA swap stage has scrambled S-memory for the current candidate key. It walks the PRGA over S-memory, XORs each keystream byte with the encrypted ROM byte, and writes the plaintext to D-memory. It flags the key invalid on the first non-lowercase, non-space plaintext byte, so the datapath FSM can move on to the next key early.

## Interface
- MSG_LEN, 32: message length in bytes; valid range 1..256.
- CHAR_LO, 8'h61: lowest valid plaintext byte ('a').
- CHAR_HI, 8'h7A: highest valid plaintext byte ('z').
- CHAR_SP, 8'h20: additional valid plaintext byte (space).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  level request from the datapath FSM; sampled only in IDLE.
- done  out  1  high in DONE; held until start drops.
- invalid  out  1  key rejected; valid whenever done=1.
- s_addr  out  8  S-RAM address.
- s_wdata  out  8  S-RAM write data.
- s_rdata  in  8  S-RAM read data.
- s_wren  out  1  S-RAM write enable.
- e_addr  out  8  encrypted ROM address.
- e_rdata  in  8  encrypted ROM read data.
- d_addr  out  8  D-RAM address.
- d_wdata  out  8  D-RAM write data.
- d_wren  out  1  D-RAM write enable.

## Operation
- Memory model: all RAM/ROM ports register the address on the clock edge. Read data appears one cycle later.
  - A read is two states: the address state, then the capture state, which samples at its end.
- Memory outputs are combinational from the state and internal registers. In IDLE and DONE they are all 0, with wren low.
- Internal 8-bit registers: i, j, si, sj, f, ek, and k (byte index). All arithmetic is mod 256.
- IDLE: when start=1, clear i, j, k and invalid, then go to RD_I.
- Per-byte state sequence (9 states):
  - RD_I: s_addr=i+1; i<=i+1.
  - CAP_I: si<=s_rdata; j<=j+s_rdata.
  - RD_J: s_addr=j.
  - CAP_J: sj<=s_rdata.
  - WR_J: s_addr=j, s_wdata=si, s_wren=1.
  - WR_I: s_addr=i, s_wdata=sj, s_wren=1.
  - RD_F: s_addr=si+sj; e_addr=k.
  - CAP_F: f<=s_rdata; ek<=e_rdata. Hold e_addr=k.
  - WR_D: d_addr=k, d_wdata=f^ek, d_wren=1.
- Exit from WR_D:
  - If f^ek is outside [CHAR_LO..CHAR_HI] and not CHAR_SP: invalid<=1, go to DONE. The byte is still written.
  - Else if k==MSG_LEN-1: go to DONE with invalid=0.
  - Else: k<=k+1, go to RD_I.
- DONE: done=1. Stay while start=1; go to IDLE on the cycle after start=0.
- i==j case: both writes hit the same location with the same value. No special handling is required.
- reset at any time: return to IDLE immediately and drive done=0 and invalid=0. Registers i, j, k, si, sj, f and ek go to 0. Partially written D/S contents are not restored.

## Timing
- Start sampled in IDLE at edge 0: RD_I occupies cycle 1.
- Byte n occupies cycles 9n+1 .. 9n+9; WR_D is cycle 9n+9.
- Fully valid message: done rises at cycle 9*MSG_LEN+1 (289 for 32 bytes).
- Rejection at byte n: done rises at cycle 9n+10.
- invalid is stable from the done rising edge until the next IDLE exit.
- The block never writes S and D in the same cycle.
- start deasserted mid-run: ignored; the run completes normally.

## Test plan
- Identity S (s[x]=x), e[0]=8'h63, e[1]=8'h64, remaining e[k]=keystream^8'h61 from a model, start held -> d[0]=8'h61, d[1]=8'h61; S[2]=3 and S[3]=2 after byte 1; done at cycle 289; invalid=0.
- Identity S, e[1]=8'h05 -> d[1]=8'h00; d_wren pulses exactly twice; done at cycle 19; invalid=1; d[2..] untouched.
- Boundary chars: plaintext bytes 8'h20, 8'h61 and 8'h7A accepted; 8'h60, 8'h7B and 8'h1F each reject at their byte index.
- Reset asserted at cycle 50 -> done=0, invalid=0, all wren low immediately. Restart -> run from i=j=k=0 and complete as a fresh run.
- Handshake: hold start 10 cycles past done -> done stays 1. Drop start -> IDLE next cycle. Reassert start -> invalid cleared, k restarts at 0.
- Golden: S after KSA with key 24'h000249, known 32-byte message -> d matches the software RC4 model byte-for-byte; invalid=0.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + decrypt stage for the key-search datapath.
// Walks the RC4 keystream generator over S-memory, which the KSA stage has
// already scrambled. Each keystream byte is XORed with the encrypted ROM byte
// and the result is written to D-memory. The first plaintext byte that is
// neither a lowercase letter nor a space ends the run with invalid set, so
// the key search can move on early.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               level request; sampled only in IDLE
//   done                high in DONE; held until start drops
//   invalid             key rejected; valid whenever done=1
//   s_addr/s_wdata/s_rdata/s_wren   S-RAM port (1-cycle read latency)
//   e_addr/e_rdata                  encrypted ROM port (1-cycle read latency)
//   d_addr/d_wdata/d_wren           D-RAM write port
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN = 32,
    parameter logic [7:0]  CHAR_LO = 8'h61,
    parameter logic [7:0]  CHAR_HI = 8'h7A,
    parameter logic [7:0]  CHAR_SP = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       invalid,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    input  logic [7:0] s_rdata,
    output logic       s_wren,
    output logic [7:0] e_addr,
    input  logic [7:0] e_rdata,
    output logic [7:0] d_addr,
    output logic [7:0] d_wdata,
    output logic       d_wren
);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StRdI  = 4'd1;
    localparam logic [3:0] StCapI = 4'd2;
    localparam logic [3:0] StRdJ  = 4'd3;
    localparam logic [3:0] StCapJ = 4'd4;
    localparam logic [3:0] StWrJ  = 4'd5;
    localparam logic [3:0] StWrI  = 4'd6;
    localparam logic [3:0] StRdF  = 4'd7;
    localparam logic [3:0] StCapF = 4'd8;
    localparam logic [3:0] StWrD  = 4'd9;
    localparam logic [3:0] StDone = 4'd10;

    localparam logic [7:0] LastK = 8'(MSG_LEN - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] i_q, j_q, si_q, sj_q, f_q, ek_q, k_q;
    logic       invalid_q;
    logic [7:0] pt;
    logic       pt_ok;

    assign pt    = f_q ^ ek_q;
    assign pt_ok = ((pt >= CHAR_LO) && (pt <= CHAR_HI)) || (pt == CHAR_SP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRdI;
            StRdI:   state_d = StCapI;
            StCapI:  state_d = StRdJ;
            StRdJ:   state_d = StCapJ;
            StCapJ:  state_d = StWrJ;
            StWrJ:   state_d = StWrI;
            StWrI:   state_d = StRdF;
            StRdF:   state_d = StCapF;
            StCapF:  state_d = StWrD;
            StWrD:   state_d = (!pt_ok || (k_q == LastK)) ? StDone : StRdI;
            StDone:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            f_q       <= 8'd0;
            ek_q      <= 8'd0;
            k_q       <= 8'd0;
            invalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        i_q       <= 8'd0;
                        j_q       <= 8'd0;
                        k_q       <= 8'd0;
                        invalid_q <= 1'b0;
                    end
                end
                StRdI:  i_q <= i_q + 8'd1;
                StCapI: begin
                    si_q <= s_rdata;
                    j_q  <= j_q + s_rdata;
                end
                StCapJ: sj_q <= s_rdata;
                StCapF: begin
                    f_q  <= s_rdata;
                    ek_q <= e_rdata;
                end
                StWrD: begin
                    // A rejected byte is still written; only the exit changes.
                    if (!pt_ok) invalid_q <= 1'b1;
                    else if (k_q != LastK) k_q <= k_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are pure functions of state and registers.
    always_comb begin
        s_addr  = 8'd0;
        s_wdata = 8'd0;
        s_wren  = 1'b0;
        e_addr  = 8'd0;
        d_addr  = 8'd0;
        d_wdata = 8'd0;
        d_wren  = 1'b0;
        case (state_q)
            StRdI:  s_addr = i_q + 8'd1;
            StRdJ:  s_addr = j_q;
            StWrJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
            end
            StWrI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
            end
            StRdF: begin
                s_addr = si_q + sj_q;
                e_addr = k_q;
            end
            StCapF: e_addr = k_q;
            StWrD: begin
                d_addr  = k_q;
                d_wdata = pt;
                d_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    assign done    = (state_q == StDone);
    assign invalid = invalid_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt with behavioural S/E/D memories,
// an independent RC4 software model and a plaintext-write scoreboard.
module tb_rc4_prga_decrypt;

    localparam int MSG = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done, invalid;
    logic [7:0] s_addr, s_wdata, s_rdata, e_addr, e_rdata, d_addr, d_wdata;
    logic       s_wren, d_wren;

    rc4_prga_decrypt #(.MSG_LEN(MSG)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .invalid(invalid),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_wren(s_wren),
        .e_addr(e_addr), .e_rdata(e_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_init [256];
    logic [7:0] s_mem  [256];
    logic [7:0] e_mem  [256];
    logic [7:0] d_mem  [256];
    logic [7:0] ks     [256];
    logic       load = 1'b0;

    // Registered-address memories; load copies s_init and fills D with 8'hAA.
    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) begin
                s_mem[x] <= s_init[x];
                d_mem[x] <= 8'hAA;
            end
        end else begin
            if (s_wren) s_mem[s_addr] <= s_wdata;
            if (d_wren) d_mem[d_addr] <= d_wdata;
        end
        s_rdata <= s_mem[s_addr];
        e_rdata <= e_mem[e_addr];
    end

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          done_cyc, dwren_cnt, sd_both, exp_done;
    logic [7:0]  snap2, snap3;
    logic        inv_c1, inv_end;

    task automatic identity_s();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic load_mem();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Software RC4 PRGA over s_init.
    task automatic model_ks();
        logic [7:0] ms [256];
        logic [7:0] mi, mj, t, idx;
        for (int x = 0; x < 256; x++) ms[x] = s_init[x];
        mi = 0; mj = 0;
        for (int n = 0; n < MSG; n++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
            idx = ms[mi] + ms[mj];
            ks[n] = ms[idx];
        end
    endtask

    // Push expected D writes up to and including the first rejected byte.
    task automatic build_expected(output int rej);
        logic [7:0] pt;
        model_ks();
        exp_q.delete();
        got_q.delete();
        rej = -1;
        for (int k = 0; k < MSG; k++) begin
            pt = e_mem[k] ^ ks[k];
            exp_q.push_back({8'(k), pt});
            if (!(((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20))) begin
                rej = k;
                break;
            end
        end
        exp_done = (rej < 0) ? 9 * MSG + 1 : 9 * rej + 10;
    endtask

    // Assert start (edge 0) and observe each cycle #1 after its edge until done.
    task automatic run_to_done();
        int t;
        dwren_cnt = 0; sd_both = 0; done_cyc = -1; snap2 = 0; snap3 = 0;
        start = 1'b1;
        @(posedge clk);
        t = 1;
        while (1) begin
            #1;
            if (t == 1) inv_c1 = invalid;
            if (done) begin
                done_cyc = t;
                break;
            end
            if (d_wren) begin
                dwren_cnt++;
                got_q.push_back({d_addr, d_wdata});
                if (d_addr == 8'd1) begin
                    snap2 = s_mem[2];
                    snap3 = s_mem[3];
                end
            end
            if (d_wren && s_wren) sd_both++;
            if (t > 4000) begin
                tests++; fails++;
                $display("FAIL run_timeout: done not seen after %0d cycles, want %0d", t, exp_done);
                break;
            end
            @(posedge clk);
            t++;
        end
        inv_end = invalid;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({done, invalid, s_wren, d_wren, s_addr, e_addr, d_addr} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {done, invalid, s_wren, d_wren, s_addr, e_addr, d_addr});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_start: done=%b want 0", done);
        end
    endtask

    task automatic test_valid_message();
        int rej;
        identity_s();
        model_ks();
        e_mem[0] = 8'h63;
        e_mem[1] = 8'h64;
        for (int k = 2; k < MSG; k++) e_mem[k] = ks[k] ^ 8'h61;
        load_mem();
        build_expected(rej);
        run_to_done();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL valid_count: got %0d writes want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [15:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL valid_byte: got %h want %h", g, e);
            end
        end
        tests++;
        if (d_mem[0] !== 8'h61 || d_mem[1] !== 8'h61) begin
            fails++;
            $display("FAIL valid_d01: got %h %h want 61 61", d_mem[0], d_mem[1]);
        end
        tests++;
        if (snap2 !== 8'd3 || snap3 !== 8'd2) begin
            fails++;
            $display("FAIL swap_s23: got %h %h want 03 02", snap2, snap3);
        end
        tests++;
        if (done_cyc !== 289 || inv_end !== 1'b0) begin
            fails++;
            $display("FAIL valid_done: cyc %0d inv %b want 289 0", done_cyc, inv_end);
        end
        tests++;
        if (sd_both !== 0) begin
            fails++;
            $display("FAIL sd_overlap: got %0d want 0", sd_both);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early_reject();
        int rej;
        identity_s();
        e_mem[0] = 8'h63;
        e_mem[1] = 8'h05;
        for (int k = 2; k < MSG; k++) e_mem[k] = 8'h61;
        load_mem();
        build_expected(rej);
        run_to_done();
        tests++;
        if (d_mem[1] !== 8'h00 || dwren_cnt !== 2) begin
            fails++;
            $display("FAIL reject_d1: d1 %h wrens %0d want 00 2", d_mem[1], dwren_cnt);
        end
        tests++;
        if (done_cyc !== 19 || inv_end !== 1'b1) begin
            fails++;
            $display("FAIL reject_done: cyc %0d inv %b want 19 1", done_cyc, inv_end);
        end
        tests++;
        if (d_mem[2] !== 8'hAA || d_mem[31] !== 8'hAA) begin
            fails++;
            $display("FAIL reject_untouched: got %h %h want aa aa", d_mem[2], d_mem[31]);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_boundary_chars();
        logic [7:0] bad_c [3];
        int         bad_i [3];
        int         rej;
        bad_c = '{8'h60, 8'h7B, 8'h1F};
        bad_i = '{2, 5, 7};
        for (int r = 0; r < 4; r++) begin
            identity_s();
            model_ks();
            for (int k = 0; k < MSG; k++) e_mem[k] = ks[k] ^ 8'h61;
            if (r == 0) begin
                e_mem[3] = ks[3] ^ 8'h20;
                e_mem[4] = ks[4] ^ 8'h61;
                e_mem[5] = ks[5] ^ 8'h7A;
            end else begin
                e_mem[bad_i[r-1]] = ks[bad_i[r-1]] ^ bad_c[r-1];
            end
            load_mem();
            build_expected(rej);
            run_to_done();
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                logic [15:0] e, g;
                e = exp_q.pop_front(); g = got_q.pop_front();
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL boundary_byte[%0d]: got %h want %h", r, g, e);
                end
            end
            tests++;
            if (done_cyc !== exp_done || inv_end !== (r != 0)) begin
                fails++;
                $display("FAIL boundary_done[%0d]: cyc %0d inv %b want %0d %b",
                         r, done_cyc, inv_end, exp_done, (r != 0));
            end
            start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        int rej;
        identity_s();
        model_ks();
        for (int k = 0; k < MSG; k++) e_mem[k] = ks[k] ^ 8'h61;
        load_mem();
        start = 1'b1;
        @(posedge clk);
        repeat (49) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if ({done, invalid, s_wren, d_wren} !== 4'b0) begin
            fails++;
            $display("FAIL reset_mid: got %b want 0000", {done, invalid, s_wren, d_wren});
        end
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        identity_s();
        model_ks();
        for (int k = 0; k < MSG; k++) e_mem[k] = ks[k] ^ 8'h7A;
        load_mem();
        build_expected(rej);
        run_to_done();
        tests++;
        if (got_q.size() !== exp_q.size() || done_cyc !== 289 || inv_end !== 1'b0) begin
            fails++;
            $display("FAIL restart_run: writes %0d cyc %0d inv %b want %0d 289 0",
                     got_q.size(), done_cyc, inv_end, exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [15:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL restart_byte: got %h want %h", g, e);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        int rej, low_cnt;
        identity_s();
        e_mem[0] = 8'h63;
        e_mem[1] = 8'h05;
        load_mem();
        build_expected(rej);
        run_to_done();
        low_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done !== 1'b1) low_cnt++;
        end
        tests++;
        if (low_cnt !== 0 || invalid !== 1'b1) begin
            fails++;
            $display("FAIL done_held: low cycles %0d inv %b want 0 1", low_cnt, invalid);
        end
        start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL drop_start: done=%b want 0", done);
        end
        identity_s();
        model_ks();
        for (int k = 0; k < MSG; k++) e_mem[k] = ks[k] ^ 8'h61;
        load_mem();
        build_expected(rej);
        run_to_done();
        tests++;
        if (inv_c1 !== 1'b0 || got_q.size() === 0 || got_q[0][15:8] !== 8'd0) begin
            fails++;
            $display("FAIL restart_clear: inv %b first addr %h want 0 00",
                     inv_c1, (got_q.size() > 0) ? got_q[0][15:8] : 8'hxx);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_golden();
        logic [7:0] key [3];
        logic [7:0] j, t;
        string      msg;
        int         rej;
        key = '{8'h00, 8'h02, 8'h49};
        msg = "attack at dawn with the big rams";
        identity_s();
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = j + s_init[x] + key[x % 3];
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
        model_ks();
        for (int k = 0; k < MSG; k++) e_mem[k] = msg[k] ^ ks[k];
        load_mem();
        build_expected(rej);
        run_to_done();
        for (int k = 0; k < MSG; k++) begin
            tests++;
            if (d_mem[k] !== msg[k]) begin
                fails++;
                $display("FAIL golden[%0d]: got %h want %h", k, d_mem[k], msg[k]);
            end
        end
        tests++;
        if (inv_end !== 1'b0 || done_cyc !== 289) begin
            fails++;
            $display("FAIL golden_done: inv %b cyc %0d want 0 289", inv_end, done_cyc);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_valid_message();
        test_early_reject();
        test_boundary_chars();
        test_reset_mid_run();
        test_handshake();
        test_golden();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
